// File: rtl/pll_reset_pkg.sv
// rtl/pll_reset_pkg.sv - shared state encoding and cycle-count defaults for the PLL reset sequencer
package pll_reset_pkg;

    typedef enum logic [4:0] {
        WAIT_LOCK = 5'b00001,
        STABLE    = 5'b00010,
        HOLD      = 5'b00100,
        CORE_UP   = 5'b01000,
        RUN       = 5'b10000
    } state_t;

    localparam int DEF_SYNC_STAGES         = 2;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_CORE_HOLD_CYCLES    = 16;
    localparam int DEF_PERIPH_DELAY_CYCLES = 64;
    localparam int DEF_LOSS_CNT_W          = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-stage single-bit synchroniser with synchronous clear
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk) begin
        if (clr) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// rtl/pll_reset_ctrl.sv - qualifies PLL lock and sequences core/peripheral reset release
module pll_reset_ctrl
    import pll_reset_pkg::*;
#(
    parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int CORE_HOLD_CYCLES    = DEF_CORE_HOLD_CYCLES,
    parameter int PERIPH_DELAY_CYCLES = DEF_PERIPH_DELAY_CYCLES,
    parameter int LOSS_CNT_W          = DEF_LOSS_CNT_W
) (
    input  logic                  clk90,
    input  logic                  rst,
    input  logic                  locked,
    output logic                  rst_core,
    output logic                  rst_periph,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int CNT_W = $clog2(max3(LOCK_STABLE_CYCLES, CORE_HOLD_CYCLES, PERIPH_DELAY_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(CORE_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_DELAY_CYCLES - 1);

    logic             locked_s;
    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             loss_ev;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk90),
        .clr (rst),
        .d   (locked),
        .q   (locked_s)
    );

    // A loss only counts once lock had qualified (HOLD onwards).
    always_comb begin
        state_nx = state;
        loss_ev  = 1'b0;
        case (state)
            WAIT_LOCK: if (locked_s) state_nx = STABLE;
            STABLE: begin
                if (!locked_s)               state_nx = WAIT_LOCK;
                else if (cnt == STABLE_LAST) state_nx = HOLD;
            end
            HOLD: begin
                if (!locked_s) begin
                    state_nx = WAIT_LOCK;
                    loss_ev  = 1'b1;
                end else if (cnt == HOLD_LAST) begin
                    state_nx = CORE_UP;
                end
            end
            CORE_UP: begin
                if (!locked_s) begin
                    state_nx = WAIT_LOCK;
                    loss_ev  = 1'b1;
                end else if (cnt == PERIPH_LAST) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_nx = WAIT_LOCK;
                    loss_ev  = 1'b1;
                end
            end
            default: state_nx = WAIT_LOCK;
        endcase
    end

    always_comb begin
        cnt_nx = '0;
        if (state_nx == state && (state == STABLE || state == HOLD || state == CORE_UP)) begin
            cnt_nx = cnt + 1'b1;
        end
    end

    // Outputs decode state_nx so they move on the same edge as the state register.
    always_ff @(posedge clk90) begin
        if (rst) begin
            state         <= WAIT_LOCK;
            cnt           <= '0;
            rst_core      <= 1'b1;
            rst_periph    <= 1'b1;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            rst_core   <= (state_nx == WAIT_LOCK) || (state_nx == STABLE) || (state_nx == HOLD);
            rst_periph <= (state_nx != RUN);
            ready      <= (state_nx == RUN);
            if (loss_ev && lock_loss_cnt != '1) begin
                lock_loss_cnt <= lock_loss_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb/tb_pll_reset_ctrl.sv - self-checking bench for pll_reset_ctrl
module tb_pll_reset_ctrl;

    localparam int SS  = 2;
    localparam int LSC = 8;
    localparam int CH  = 4;
    localparam int PD  = 6;

    logic       clk90 = 1'b0;
    logic       rst;
    logic       locked;
    logic       rst_core, rst_periph, ready;
    logic [7:0] lock_loss_cnt;
    logic       s_rst_core, s_rst_periph, s_ready;
    logic [1:0] s_lock_loss_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: time since lock qualified start (-1 when waiting) plus a lock delay line.
    int   t = -1;
    int   mcnt8 = 0;
    int   mcnt2 = 0;
    logic dly [SS];

    always #5 clk90 = ~clk90;

    pll_reset_ctrl #(
        .SYNC_STAGES(SS), .LOCK_STABLE_CYCLES(LSC), .CORE_HOLD_CYCLES(CH),
        .PERIPH_DELAY_CYCLES(PD), .LOSS_CNT_W(8)
    ) u_dut (
        .clk90(clk90), .rst(rst), .locked(locked), .rst_core(rst_core),
        .rst_periph(rst_periph), .ready(ready), .lock_loss_cnt(lock_loss_cnt)
    );

    pll_reset_ctrl #(
        .SYNC_STAGES(SS), .LOCK_STABLE_CYCLES(LSC), .CORE_HOLD_CYCLES(CH),
        .PERIPH_DELAY_CYCLES(PD), .LOSS_CNT_W(2)
    ) u_sat (
        .clk90(clk90), .rst(rst), .locked(locked), .rst_core(s_rst_core),
        .rst_periph(s_rst_periph), .ready(s_ready), .lock_loss_cnt(s_lock_loss_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic l);
        logic ls;
        if (r) begin
            t = -1;
            mcnt8 = 0;
            mcnt2 = 0;
            for (int i = 0; i < SS; i++) dly[i] = 1'b0;
        end else begin
            ls = dly[SS-1];
            for (int i = SS - 1; i > 0; i--) dly[i] = dly[i-1];
            dly[0] = l;
            if (t < 0) begin
                if (ls) t = 0;
            end else if (!ls) begin
                if (t >= LSC) begin
                    mcnt8 = (mcnt8 < 255) ? mcnt8 + 1 : 255;
                    mcnt2 = (mcnt2 < 3) ? mcnt2 + 1 : 3;
                end
                t = -1;
            end else begin
                t++;
            end
        end
    endtask

    task automatic step(input logic r, input logic l);
        int exp_rdy;
        rst = r;
        locked = l;
        @(posedge clk90);
        #1;
        model_edge(r, l);
        exp_rdy = (t >= LSC + CH + PD) ? 1 : 0;
        chk("model rst_core",   int'(rst_core),   (t >= LSC + CH) ? 0 : 1);
        chk("model rst_periph", int'(rst_periph), 1 - exp_rdy);
        chk("model ready",      int'(ready),      exp_rdy);
        chk("model cnt8",       int'(lock_loss_cnt),   mcnt8);
        chk("model cnt2",       int'(s_lock_loss_cnt), mcnt2);
        chk("model sat ready",  int'(s_ready),    exp_rdy);
    endtask

    typedef struct {
        logic r;
        logic l;
        int   n;
        logic ec;
        logic ep;
        logic er;
        int   ecnt;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int fall;
        int got;
        int exp_sat[5];
        int rl, ll;
        logic rr;

        rst = 1'b1;
        locked = 1'b0;

        tbl[0]  = '{1'b1, 1'b1, 3,  1'b1, 1'b1, 1'b0, 0};
        tbl[1]  = '{1'b0, 1'b1, 14, 1'b1, 1'b1, 1'b0, 0};
        tbl[2]  = '{1'b0, 1'b1, 1,  1'b0, 1'b1, 1'b0, 0};
        tbl[3]  = '{1'b0, 1'b1, 5,  1'b0, 1'b1, 1'b0, 0};
        tbl[4]  = '{1'b0, 1'b1, 1,  1'b0, 1'b0, 1'b1, 0};
        tbl[5]  = '{1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b1, 0};
        tbl[6]  = '{1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1};
        tbl[7]  = '{1'b0, 1'b1, 14, 1'b1, 1'b1, 1'b0, 1};
        tbl[8]  = '{1'b0, 1'b1, 1,  1'b0, 1'b1, 1'b0, 1};
        tbl[9]  = '{1'b0, 1'b1, 6,  1'b0, 1'b0, 1'b1, 1};
        tbl[10] = '{1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b0, 2};
        tbl[11] = '{1'b0, 1'b1, 15, 1'b0, 1'b1, 1'b0, 2};
        tbl[12] = '{1'b1, 1'b1, 1,  1'b1, 1'b1, 1'b0, 0};

        for (int v = 0; v < 13; v++) begin
            for (int c = 0; c < tbl[v].n; c++) step(tbl[v].r, tbl[v].l);
            chk($sformatf("vec%0d rst_core", v),   int'(rst_core),   int'(tbl[v].ec));
            chk($sformatf("vec%0d rst_periph", v), int'(rst_periph), int'(tbl[v].ep));
            chk($sformatf("vec%0d ready", v),      int'(ready),      int'(tbl[v].er));
            chk($sformatf("vec%0d cnt", v),        int'(lock_loss_cnt), tbl[v].ecnt);
            chk($sformatf("vec%0d sat cnt", v),    int'(s_lock_loss_cnt),
                (tbl[v].ecnt > 3) ? 3 : tbl[v].ecnt);
        end

        // Single-cycle glitch while qualifying: release restarts from the new lock edge.
        step(1'b1, 1'b1);
        fall = -1;
        for (int e = 1; e <= 40; e++) begin
            step(1'b0, (e == 9) ? 1'b0 : 1'b1);
            if (fall < 0 && rst_core == 1'b0) fall = e;
        end
        chk("glitch rst_core fall edge", fall, 24);
        chk("glitch cnt", int'(lock_loss_cnt), 0);

        // Saturation of the 2-bit loss counter.
        exp_sat = '{1, 2, 3, 3, 3};
        step(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            got = 0;
            for (int c = 0; c < 40 && got == 0; c++) begin
                step(1'b0, 1'b1);
                if (s_ready) got = 1;
            end
            chk("sat reached ready", got, 1);
            for (int c = 0; c < SS + 1; c++) step(1'b0, 1'b0);
            chk("sat cnt", int'(s_lock_loss_cnt), exp_sat[k]);
            chk("wide cnt", int'(lock_loss_cnt), k + 1);
        end

        // Random lock runs with occasional external reset.
        step(1'b1, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            rl = $urandom_range(1, 30);
            ll = ($urandom_range(0, 3) != 0) ? 1 : 0;
            for (int c = 0; c < rl; c++) begin
                rr = ($urandom_range(0, 199) == 0);
                step(rr, ll[0]);
                n++;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
